// File: rtl/alarm_ctrl.sv
// Alarm sequencing controller: debounces the arm/snooze/stop keys and runs the
// DISARMED/ARMED/RINGING/SNOOZE machine that drives the buzzer and status outputs.
module alarm_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk_1,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic       match,
  input  logic       key_arm,
  input  logic       key_snooze,
  input  logic       key_stop,
  output logic       armed,
  output logic       ringing,
  output logic       snoozing,
  output logic       buzzer,
  output logic [1:0] snooze_cnt
);

  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  localparam logic [1:0] ST_DISARMED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_RINGING  = 2'd2;
  localparam logic [1:0] ST_SNOOZE   = 2'd3;

  // Bit 2 = arm, bit 1 = snooze, bit 0 = stop.
  logic [2:0] key_raw;
  logic [2:0] press;

  assign key_raw = {key_arm, key_snooze, key_stop};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_key
      logic             sync1_reg;
      logic             sync2_reg;
      logic             deb_reg;
      logic             deb_d_reg;
      logic             press_reg;
      logic [DEB_W-1:0] cnt_reg;

      // The press pulse is registered so every key path has the same fixed latency.
      always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          deb_reg   <= 1'b0;
          deb_d_reg <= 1'b0;
          press_reg <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg != deb_reg) begin
            if (cnt_reg == DEB_W'(DEB_CYCLES - 1)) begin
              deb_reg <= sync2_reg;
              cnt_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + DEB_W'(1);
            end
          end else begin
            cnt_reg <= '0;
          end
          deb_d_reg <= deb_reg;
          press_reg <= deb_reg & ~deb_d_reg;
        end
      end

      assign press[gi] = press_reg;
    end
  endgenerate

  logic       arm_p;
  logic       snooze_p;
  logic       stop_p;
  logic       match_rise;
  logic       expiry;

  logic [1:0] state_reg, state_next;
  logic [9:0] timer_reg, timer_next;
  logic       phase_reg, phase_next;
  logic [1:0] cnt_reg, cnt_next;
  logic       match_d_reg;

  assign arm_p      = press[2];
  assign snooze_p   = press[1];
  assign stop_p     = press[0];
  assign match_rise = match & ~match_d_reg;
  assign expiry     = sec_tick && (timer_reg == 10'd1);

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    phase_next = phase_reg;
    cnt_next   = cnt_reg;

    // Default timing behaviour; any load below overrides it, so a tick on a load is dropped.
    if (sec_tick && (state_reg == ST_RINGING || state_reg == ST_SNOOZE))
      timer_next = timer_reg - 10'd1;
    if (sec_tick && state_reg == ST_RINGING)
      phase_next = ~phase_reg;

    case (state_reg)
      ST_DISARMED: begin
        if (arm_p) begin
          state_next = ST_ARMED;
          cnt_next   = 2'd0;
        end
      end
      ST_ARMED: begin
        if (arm_p) begin
          state_next = ST_DISARMED;
          cnt_next   = 2'd0;
        end else if (match_rise) begin
          state_next = ST_RINGING;
          timer_next = 10'(RING_SEC);
          phase_next = 1'b1;
          cnt_next   = 2'd0;
        end
      end
      ST_RINGING: begin
        if (arm_p) begin
          state_next = ST_DISARMED;
          cnt_next   = 2'd0;
          timer_next = 10'd0;
        end else if (stop_p) begin
          state_next = ST_ARMED;
          cnt_next   = 2'd0;
          timer_next = 10'd0;
        end else if (snooze_p && (cnt_reg < 2'(MAX_SNOOZE))) begin
          state_next = ST_SNOOZE;
          cnt_next   = cnt_reg + 2'd1;
          timer_next = 10'(SNOOZE_SEC);
        end else if (expiry) begin
          state_next = ST_ARMED;
          cnt_next   = 2'd0;
          timer_next = 10'd0;
        end
      end
      ST_SNOOZE: begin
        if (arm_p) begin
          state_next = ST_DISARMED;
          cnt_next   = 2'd0;
          timer_next = 10'd0;
        end else if (stop_p) begin
          state_next = ST_ARMED;
          cnt_next   = 2'd0;
          timer_next = 10'd0;
        end else if (expiry) begin
          state_next = ST_RINGING;
          timer_next = 10'(RING_SEC);
          phase_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_DISARMED;
      timer_reg   <= 10'd0;
      phase_reg   <= 1'b0;
      cnt_reg     <= 2'd0;
      match_d_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      phase_reg   <= phase_next;
      cnt_reg     <= cnt_next;
      match_d_reg <= match;
    end
  end

  assign armed      = (state_reg != ST_DISARMED);
  assign ringing    = (state_reg == ST_RINGING);
  assign snoozing   = (state_reg == ST_SNOOZE);
  assign buzzer     = ringing & phase_reg;
  assign snooze_cnt = cnt_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: stimulus queues expected output vectors with
// their due cycle; a negedge monitor compares on every output change or probe.
module tb_alarm_ctrl;

  logic       clk_1 = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_tick = 1'b0;
  logic       match = 1'b0;
  logic       key_arm = 1'b0;
  logic       key_snooze = 1'b0;
  logic       key_stop = 1'b0;
  logic       armed, ringing, snoozing, buzzer;
  logic [1:0] snooze_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [5:0] out;
    int         cyc;
    bit         probe;
    string      name;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [5:0] mon_o;
  logic [5:0] last_out = 6'h3f;

  alarm_ctrl #(
    .DEB_CYCLES(16),
    .RING_SEC  (4),
    .SNOOZE_SEC(3),
    .MAX_SNOOZE(3)
  ) dut (
    .clk_1     (clk_1),
    .rst_n     (rst_n),
    .sec_tick  (sec_tick),
    .match     (match),
    .key_arm   (key_arm),
    .key_snooze(key_snooze),
    .key_stop  (key_stop),
    .armed     (armed),
    .ringing   (ringing),
    .snoozing  (snoozing),
    .buzzer    (buzzer),
    .snooze_cnt(snooze_cnt)
  );

  initial forever #5 clk_1 = ~clk_1;

  initial forever begin
    @(posedge clk_1);
    cyc = cyc + 1;
  end

  // Output vector layout: {armed, ringing, snoozing, buzzer, snooze_cnt}.
  function automatic logic [5:0] mk(input bit a, input bit r, input bit s, input bit b,
                                    input logic [1:0] c);
    return {a, r, s, b, c};
  endfunction

  task automatic push_chg(input logic [5:0] o, input int c, input string nm);
    exp_t e;
    e.out = o; e.cyc = c; e.probe = 1'b0; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic push_probe(input logic [5:0] o, input int c, input string nm);
    exp_t e;
    e.out = o; e.cyc = c; e.probe = 1'b1; e.name = nm;
    sb.push_back(e);
  endtask

  // keys = {arm, snooze, stop}; a change is due 20 negedges after the drive point.
  task automatic press(input logic [2:0] keys, input int hold, input int tick_i,
                       input logic [5:0] o, input bit chg, input string nm);
    int n;
    @(negedge clk_1);
    n = cyc;
    if (chg) push_chg(o, n + 20, nm);
    else     push_probe(o, n + 22, nm);
    {key_arm, key_snooze, key_stop} = keys;
    for (int i = 0; i < hold; i++) begin
      sec_tick = (i == tick_i);
      @(negedge clk_1);
    end
    sec_tick = 1'b0;
    {key_arm, key_snooze, key_stop} = 3'b000;
    repeat (25) @(negedge clk_1);
  endtask

  task automatic tick(input logic [5:0] o, input bit chg, input string nm);
    int n;
    @(negedge clk_1);
    n = cyc;
    if (chg) push_chg(o, n + 1, nm);
    else     push_probe(o, n + 1, nm);
    sec_tick = 1'b1;
    @(negedge clk_1);
    sec_tick = 1'b0;
    repeat (2) @(negedge clk_1);
  endtask

  task automatic match_rise(input logic [5:0] o, input string nm);
    int n;
    @(negedge clk_1);
    n = cyc;
    push_chg(o, n + 1, nm);
    match = 1'b1;
    repeat (3) @(negedge clk_1);
  endtask

  task automatic match_fall();
    @(negedge clk_1);
    match = 1'b0;
    repeat (3) @(negedge clk_1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk_1);
      mon_o = {armed, ringing, snoozing, buzzer, snooze_cnt};
      if (sb.size() > 0 && sb[0].cyc >= 0 && cyc > sb[0].cyc) begin
        mon_e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: outputs %b at cycle %0d, required %b by cycle %0d",
                 mon_e.name, mon_o, cyc, mon_e.out, mon_e.cyc);
      end else if (sb.size() > 0 && sb[0].probe && cyc == sb[0].cyc) begin
        mon_e = sb.pop_front();
        checks++;
        if (mon_o !== mon_e.out) begin
          errors++;
          $display("FAIL %s: outputs %b at cycle %0d, required %b",
                   mon_e.name, mon_o, cyc, mon_e.out);
        end else begin
          $display("ok   %s: outputs %b held at cycle %0d", mon_e.name, mon_o, cyc);
        end
      end else if (mon_o !== last_out) begin
        checks++;
        if (sb.size() == 0 || sb[0].probe) begin
          errors++;
          $display("FAIL unexpected_change: outputs %b -> %b at cycle %0d, required no change",
                   last_out, mon_o, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_o !== mon_e.out || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
            errors++;
            $display("FAIL %s: outputs %b at cycle %0d, required %b at cycle %0d",
                     mon_e.name, mon_o, cyc, mon_e.out, mon_e.cyc);
          end else begin
            $display("ok   %s: outputs %b at cycle %0d", mon_e.name, mon_o, cyc);
          end
        end
      end
      last_out = mon_o;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [5:0] st_armed;
    st_armed = mk(1, 0, 0, 0, 2'd0);

    push_chg(6'd0, -1, "reset");
    repeat (3) @(negedge clk_1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_1);

    // Arm, disarm, glitch rejection, re-arm.
    press(3'b100, 20, -1, st_armed, 1'b1, "arm");
    press(3'b100, 20, -1, 6'd0, 1'b1, "disarm");
    press(3'b100, 10, -1, 6'd0, 1'b0, "glitch_ignored");
    press(3'b100, 20, -1, st_armed, 1'b1, "rearm");

    // Ring with beep pattern, auto-stop, no re-trigger while match stays high.
    match_rise(mk(1, 1, 0, 1, 2'd0), "ring");
    tick(mk(1, 1, 0, 0, 2'd0), 1'b1, "beep_off1");
    tick(mk(1, 1, 0, 1, 2'd0), 1'b1, "beep_on2");
    tick(mk(1, 1, 0, 0, 2'd0), 1'b1, "beep_off3");
    tick(st_armed, 1'b1, "auto_stop");
    @(negedge clk_1);
    push_probe(st_armed, cyc + 3, "no_rering");
    repeat (5) @(negedge clk_1);
    tick(st_armed, 1'b0, "tick_in_armed");
    match_fall();

    // Three snoozes, each returning to ringing after three ticks.
    match_rise(mk(1, 1, 0, 1, 2'd0), "ring2");
    for (int k = 1; k <= 3; k++) begin
      press(3'b010, 20, -1, mk(1, 0, 1, 0, 2'(k)), 1'b1, "snooze");
      tick(mk(1, 0, 1, 0, 2'(k)), 1'b0, "snooze_tick1");
      tick(mk(1, 0, 1, 0, 2'(k)), 1'b0, "snooze_tick2");
      tick(mk(1, 1, 0, 1, 2'(k)), 1'b1, "snooze_resume");
    end
    press(3'b010, 20, -1, mk(1, 1, 0, 1, 2'd3), 1'b0, "snooze4_ignored");
    press(3'b001, 20, -1, st_armed, 1'b1, "stop_ringing");

    // Stop from snooze.
    match_fall();
    match_rise(mk(1, 1, 0, 1, 2'd0), "ring3");
    press(3'b010, 20, -1, mk(1, 0, 1, 0, 2'd1), 1'b1, "snooze_again");
    press(3'b001, 20, -1, st_armed, 1'b1, "stop_snooze");

    // Arm beats stop in the same cycle.
    match_fall();
    match_rise(mk(1, 1, 0, 1, 2'd0), "ring4");
    press(3'b101, 20, -1, 6'd0, 1'b1, "arm_stop_priority");

    // Snooze press coincident with the expiring tick wins; load-cycle tick is not counted.
    press(3'b100, 20, -1, st_armed, 1'b1, "rearm2");
    match_fall();
    match_rise(mk(1, 1, 0, 1, 2'd0), "ring5");
    tick(mk(1, 1, 0, 0, 2'd0), 1'b1, "ring5_t1");
    tick(mk(1, 1, 0, 1, 2'd0), 1'b1, "ring5_t2");
    tick(mk(1, 1, 0, 0, 2'd0), 1'b1, "ring5_t3");
    press(3'b010, 20, 19, mk(1, 0, 1, 0, 2'd1), 1'b1, "snooze_vs_expiry");
    tick(mk(1, 0, 1, 0, 2'd1), 1'b0, "load_tick_t1");
    tick(mk(1, 0, 1, 0, 2'd1), 1'b0, "load_tick_t2");
    tick(mk(1, 1, 0, 1, 2'd1), 1'b1, "load_tick_resume");

    // Asynchronous reset in the middle of a snooze.
    press(3'b010, 20, -1, mk(1, 0, 1, 0, 2'd2), 1'b1, "snooze_before_reset");
    @(posedge clk_1);
    #1;
    push_chg(6'd0, cyc, "reset_mid_snooze");
    rst_n = 1'b0;
    repeat (2) @(negedge clk_1);
    rst_n = 1'b1;
    match_fall();
    @(negedge clk_1);
    match = 1'b1;
    push_probe(6'd0, cyc + 3, "no_ring_after_reset");
    repeat (5) @(negedge clk_1);
    tick(6'd0, 1'b0, "tick_disarmed");
    repeat (5) @(negedge clk_1);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
